// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array sequencer.
// Word stride is fixed by the memory word width.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CLEAR,
        FEED,
        WAIT,
        DRAIN,
        DONE
    } sa_ctrl_state_e;

    localparam int SA_DATA_WIDTH = 32;
    localparam int WORD_BYTES    = SA_DATA_WIDTH / 8;

endpackage

// File: rtl/sa_res_serializer.sv
// Holds one result row and emits it as N single-word writes, lowest column first.
// Latency: row captured in 1 cycle, then one word per accepted write.
// Backpressure: row_ready only while empty; each word waits on wr_ready.
module sa_res_serializer #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    row_valid,
    output logic                    row_ready,
    input  logic [N*DATA_WIDTH-1:0] row_data,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [CW-1:0]           wr_col,
    output logic                    wr_last
);

    logic                    full_q;
    logic [N*DATA_WIDTH-1:0] row_q;
    logic [CW-1:0]           j_q;

    assign row_ready = !full_q;
    assign wr_valid  = full_q;
    assign wr_data   = row_q[j_q*DATA_WIDTH +: DATA_WIDTH];
    assign wr_col    = j_q;
    assign wr_last   = (j_q == CW'(N - 1));

    // A new row is only taken once the last word of the previous one has left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            row_q  <= '0;
            j_q    <= '0;
        end else if (row_valid && !full_q) begin
            full_q <= 1'b1;
            row_q  <= row_data;
            j_q    <= '0;
        end else if (full_q && wr_ready) begin
            if (wr_last) begin
                full_q <= 1'b0;
            end else begin
                j_q <= j_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sa_ctrl.sv
// Sequences one NxN matmul: loads A/B over the memory port, feeds K-slices, drains C rows as writes.
// Zero-wait memory: first feed beat 1+4N cycles after start; drain takes N*(N+1) cycles.
// Requests hold while stalled, one read outstanding; result rows throttled via sa_res_ready.
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int N          = 4,
    parameter int EW         = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_addr_A,
    input  logic [ADDR_WIDTH-1:0]   i_addr_B,
    input  logic [ADDR_WIDTH-1:0]   i_addr_C,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_we,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
    input  logic                    mem_rsp_err,
    output logic                    sa_clear,
    output logic                    sa_feed_valid,
    output logic [N*EW-1:0]         sa_feed_a,
    output logic [N*EW-1:0]         sa_feed_b,
    input  logic                    sa_done,
    input  logic                    sa_res_valid,
    output logic                    sa_res_ready,
    input  logic [N*DATA_WIDTH-1:0] sa_res_data
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (DATA_WIDTH != N * EW || DATA_WIDTH != 8 * WORD_BYTES) begin : g_width_check
            $error("sa_ctrl: DATA_WIDTH must equal N*EW and 8*WORD_BYTES");
        end
    endgenerate

    sa_ctrl_state_e state_q, state_d;

    logic [CW-1:0]         k_q, i_q;
    logic                  rd_pend_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] base_a_q, base_b_q, base_c_q;
    logic [N*EW-1:0]       abuf_q [N];
    logic [N*EW-1:0]       bbuf_q [N];

    logic                  load_st, rsp_ok, k_last, i_last;
    logic                  row_valid, row_ready;
    logic                  wr_valid, wr_ready, wr_last;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [CW-1:0]         wr_col;

    assign load_st = (state_q == LOAD_A) || (state_q == LOAD_B);
    // Responses only count while a read is actually pending.
    assign rsp_ok  = load_st && rd_pend_q && mem_rsp_valid;
    assign k_last  = (k_q == CW'(N - 1));
    assign i_last  = (i_q == CW'(N - 1));

    assign row_valid    = sa_res_valid && (state_q == DRAIN);
    assign sa_res_ready = row_ready && (state_q == DRAIN);
    assign wr_ready     = mem_req_ready && (state_q == DRAIN);

    sa_res_serializer #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH),
        .CW         (CW)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (sa_res_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_col    (wr_col),
        .wr_last   (wr_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (i_start) state_d = LOAD_A;
            LOAD_A: if (rsp_ok) begin
                        if (mem_rsp_err)  state_d = IDLE;
                        else if (k_last)  state_d = LOAD_B;
                    end
            LOAD_B: if (rsp_ok) begin
                        if (mem_rsp_err)  state_d = IDLE;
                        else if (k_last)  state_d = CLEAR;
                    end
            CLEAR:  state_d = FEED;
            FEED:   if (k_last) state_d = WAIT;
            WAIT:   if (sa_done) state_d = DRAIN;
            DRAIN:  if (wr_valid && wr_ready && wr_last && i_last) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            i_q       <= '0;
            rd_pend_q <= 1'b0;
            err_q     <= 1'b0;
            base_a_q  <= '0;
            base_b_q  <= '0;
            base_c_q  <= '0;
            for (int n = 0; n < N; n++) begin
                abuf_q[n] <= '0;
                bbuf_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (i_start) begin
                    base_a_q  <= i_addr_A;
                    base_b_q  <= i_addr_B;
                    base_c_q  <= i_addr_C;
                    err_q     <= 1'b0;
                    k_q       <= '0;
                    i_q       <= '0;
                    rd_pend_q <= 1'b0;
                end
                LOAD_A, LOAD_B: begin
                    if (!rd_pend_q && mem_req_ready) begin
                        rd_pend_q <= 1'b1;
                    end else if (rsp_ok) begin
                        rd_pend_q <= 1'b0;
                        if (mem_rsp_err) begin
                            err_q <= 1'b1;
                        end else begin
                            if (state_q == LOAD_A) abuf_q[k_q] <= mem_rsp_rdata;
                            else                   bbuf_q[k_q] <= mem_rsp_rdata;
                            k_q <= k_last ? '0 : k_q + CW'(1);
                        end
                    end
                end
                FEED: k_q <= k_last ? '0 : k_q + CW'(1);
                DRAIN: if (wr_valid && wr_ready && wr_last) i_q <= i_q + CW'(1);
                default: ;
            endcase
        end
    end

    assign o_busy        = (state_q != IDLE) && (state_q != DONE);
    assign o_done        = (state_q == DONE);
    assign o_err         = err_q;
    assign sa_clear      = (state_q == CLEAR);
    assign sa_feed_valid = (state_q == FEED);
    assign sa_feed_a     = (state_q == FEED) ? abuf_q[k_q] : '0;
    assign sa_feed_b     = (state_q == FEED) ? bbuf_q[k_q] : '0;

    // Single memory port: reads during the loads, result writes during the drain.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        if (load_st) begin
            mem_req_valid = !rd_pend_q;
            mem_req_addr  = ((state_q == LOAD_B) ? base_b_q : base_a_q)
                          + ADDR_WIDTH'(k_q) * ADDR_WIDTH'(WORD_BYTES);
        end else if (state_q == DRAIN) begin
            mem_req_valid = wr_valid;
            mem_req_we    = 1'b1;
            mem_req_addr  = base_c_q
                          + (ADDR_WIDTH'(i_q) * ADDR_WIDTH'(N) + ADDR_WIDTH'(wr_col))
                          * ADDR_WIDTH'(WORD_BYTES);
            mem_req_wdata = wr_data;
        end
    end

endmodule
